// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared types and constants for the instruction fetch unit.
//   fetch_state_t    : fetch control states (boot, run, fault)
//   INSTR_BYTES      : byte stride between sequential instructions
//   DEFAULT_RESET_PC : first fetch address after reset
//   is_misaligned()  : true when a byte address is not instruction aligned
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_t;

    localparam int          INSTR_BYTES      = 4;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_0000_0004;

    function automatic logic is_misaligned(input logic [63:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_reg.sv
// pc_reg
// Program counter register with redirect / sequential-advance / hold muxing.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : synchronous active-low reset, loads RESET_PC
//   redirect : load target (highest priority after reset)
//   target   : redirect byte address
//   advance  : step to the next sequential instruction
//   pc       : current fetch address
module pc_reg
    import fetch_pkg::*;
#(
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect,
    input  logic [PC_W-1:0] target,
    input  logic            advance,
    output logic [PC_W-1:0] pc
);

    // Redirect wins over sequential advance; with neither asserted the PC
    // simply holds. The add wraps naturally modulo 2^PC_W.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= target;
        end else if (advance) begin
            pc <= pc + PC_W'(INSTR_BYTES);
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
// Single-stage instruction fetch: drives a PC to instruction memory, registers
// the returned instruction for decode with a valid/ready handshake, handles
// taken-branch redirects (flushing the output register) and traps misaligned
// redirect targets into a sticky fault state.
// Ports:
//   clk, rst_n          : clock and synchronous active-low reset
//   redirect_valid_i    : taken branch/jump this cycle
//   redirect_target_i   : redirect byte address
//   stall_i             : global hold of PC and output register
//   instr_i             : instruction memory data for pc_o (combinational)
//   ready_i             : decode accepts instr_o this cycle
//   pc_o                : current fetch address
//   instr_o, instr_pc_o : registered instruction and its address
//   valid_o             : instr_o/instr_pc_o valid
//   fault_o             : sticky misaligned-redirect flag
//   fetch_count_o       : number of instructions accepted by decode
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                   WIDTH    = 32,
    parameter logic [2*WIDTH-1:0]   RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 redirect_valid_i,
    input  logic [2*WIDTH-1:0]   redirect_target_i,
    input  logic                 stall_i,
    input  logic [WIDTH-1:0]     instr_i,
    input  logic                 ready_i,
    output logic [2*WIDTH-1:0]   pc_o,
    output logic [WIDTH-1:0]     instr_o,
    output logic [2*WIDTH-1:0]   instr_pc_o,
    output logic                 valid_o,
    output logic                 fault_o,
    output logic [31:0]          fetch_count_o
);

    fetch_state_t state;
    fetch_state_t state_next;

    logic load_en;
    logic take_redirect;
    logic trap;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Next state: boot lasts exactly one cycle; a misaligned redirect parks
    // the unit in FAULT until the next reset.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_BOOT:  state_next = ST_RUN;
            ST_RUN: begin
                if (redirect_valid_i && is_misaligned(64'(redirect_target_i))) begin
                    state_next = ST_FAULT;
                end
            end
            ST_FAULT: state_next = ST_FAULT;
            default:  state_next = ST_BOOT;
        endcase
    end

    // Control decode. A redirect outranks stall and backpressure. A new
    // instruction is loaded only when the output slot is empty or being
    // drained this cycle, so a held instruction is never dropped or repeated.
    always_comb begin
        load_en       = 1'b0;
        take_redirect = 1'b0;
        trap          = 1'b0;
        if (state == ST_RUN) begin
            if (redirect_valid_i) begin
                take_redirect = 1'b1;
                trap          = is_misaligned(64'(redirect_target_i));
            end else if (!stall_i && (!valid_o || ready_i)) begin
                load_en = 1'b1;
            end
        end
    end

    pc_reg #(
        .PC_W     (2*WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .redirect (take_redirect),
        .target   (redirect_target_i),
        .advance  (load_en),
        .pc       (pc_o)
    );

    // Output register. A redirect flushes whatever is held; if decode took
    // that instruction in the same cycle it is still counted below.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_o    <= '0;
            instr_pc_o <= '0;
            valid_o    <= 1'b0;
            fault_o    <= 1'b0;
        end else begin
            if (load_en) begin
                instr_o    <= instr_i;
                instr_pc_o <= pc_o;
                valid_o    <= 1'b1;
            end else if (take_redirect) begin
                valid_o    <= 1'b0;
            end
            if (trap) begin
                fault_o <= 1'b1;
            end
        end
    end

    // Accepted-instruction counter, free-running and wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_count_o <= '0;
        end else if (valid_o && ready_i) begin
            fetch_count_o <= fetch_count_o + 32'd1;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit
// Directed bench for pc_fetch_unit. Stimulus pushes the addresses it expects
// decode to accept into a queue; a monitor pops and compares on every
// accepted handshake. Point checks of PC/valid/fault/count follow each edge.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid_i;
    logic [63:0] redirect_target_i;
    logic        stall_i;
    logic [31:0] instr_i;
    logic        ready_i;
    logic [63:0] pc_o;
    logic [31:0] instr_o;
    logic [63:0] instr_pc_o;
    logic        valid_o;
    logic        fault_o;
    logic [31:0] fetch_count_o;

    int total = 0;
    int bad   = 0;
    logic [63:0] expq[$];

    pc_fetch_unit dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .redirect_valid_i  (redirect_valid_i),
        .redirect_target_i (redirect_target_i),
        .stall_i           (stall_i),
        .instr_i           (instr_i),
        .ready_i           (ready_i),
        .pc_o              (pc_o),
        .instr_o           (instr_o),
        .instr_pc_o        (instr_pc_o),
        .valid_o           (valid_o),
        .fault_o           (fault_o),
        .fetch_count_o     (fetch_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model: each word is a fixed scramble of its address.
    function automatic logic [31:0] memWord(input logic [63:0] addr);
        return addr[31:0] ^ 32'hA5A5_0000;
    endfunction

    assign instr_i = memWord(pc_o);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rv, input logic [63:0] tgt,
                                 input logic st, input logic rdy);
        redirect_valid_i  = rv;
        redirect_target_i = tgt;
        stall_i           = st;
        ready_i           = rdy;
    endtask

    task automatic checkVal(input string name, input logic [63:0] act,
                            input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic [63:0] epc,
                               input logic evalid, input logic efault,
                               input logic [31:0] ecount);
        checkVal({name, ".pc"},    pc_o,                 epc);
        checkVal({name, ".valid"}, 64'(valid_o),         64'(evalid));
        checkVal({name, ".fault"}, 64'(fault_o),         64'(efault));
        checkVal({name, ".count"}, 64'(fetch_count_o),   64'(ecount));
    endtask

    // Scoreboard monitor: sampled mid-cycle, a valid&&ready means the next
    // rising edge completes an accept.
    always @(negedge clk) begin
        if (rst_n && valid_o && ready_i) begin
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_accept: got pc %h expected none", instr_pc_o);
            end else begin
                logic [63:0] e;
                e = expq.pop_front();
                checkVal("accept.pc",    instr_pc_o,       e);
                checkVal("accept.instr", 64'(instr_o),     64'(memWord(e)));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("reset", 64'h4, 1'b0, 1'b0, 32'd0);
        checkVal("reset.instr",    64'(instr_o), 64'h0);
        checkVal("reset.instr_pc", instr_pc_o,   64'h0);

        // Streaming from reset: boot cycle, then one-cycle fetch latency.
        expq.push_back(64'h4);
        expq.push_back(64'h8);
        expq.push_back(64'hC);
        expq.push_back(64'h10);
        rst_n = 1'b1;
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b1);
        tick();
        checkOutput("boot", 64'h4, 1'b0, 1'b0, 32'd0);
        tick();
        checkOutput("first_load", 64'h8, 1'b1, 1'b0, 32'd0);
        checkVal("first_load.instr_pc", instr_pc_o, 64'h4);
        tick();
        tick();
        tick();
        checkOutput("three_accepts", 64'h14, 1'b1, 1'b0, 32'd3);
        checkVal("three_accepts.instr_pc", instr_pc_o, 64'h10);

        // Backpressure: held for three cycles, then exactly one accept.
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("bp_hold", 64'h14, 1'b1, 1'b0, 32'd3);
            checkVal("bp_hold.instr_pc", instr_pc_o,   64'h10);
            checkVal("bp_hold.instr",    64'(instr_o), 64'(memWord(64'h10)));
        end
        expq.push_back(64'h14);
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b1);
        tick();
        checkOutput("bp_release", 64'h18, 1'b1, 1'b0, 32'd4);
        checkVal("bp_release.instr_pc", instr_pc_o, 64'h14);

        // Redirect during an accept: the accept counts, then flush.
        expq.push_back(64'h100);
        applyStimulus(1'b1, 64'h100, 1'b0, 1'b1);
        tick();
        checkOutput("redir_flush", 64'h100, 1'b0, 1'b0, 32'd5);
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b1);
        tick();
        checkOutput("redir_first", 64'h104, 1'b1, 1'b0, 32'd5);
        checkVal("redir_first.instr_pc", instr_pc_o, 64'h100);
        tick();
        checkOutput("redir_next", 64'h108, 1'b1, 1'b0, 32'd6);

        // Five-cycle stall: everything holds.
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("stall_hold", 64'h108, 1'b1, 1'b0, 32'd6);
            checkVal("stall_hold.instr_pc", instr_pc_o, 64'h104);
        end
        // Redirect under stall still takes effect; 0x104 is flushed.
        applyStimulus(1'b1, 64'h200, 1'b1, 1'b0);
        tick();
        checkOutput("stall_redir", 64'h200, 1'b0, 1'b0, 32'd6);

        // Redirect to the top of the address space: PC wraps to zero.
        expq.push_back(64'hFFFF_FFFF_FFFF_FFFC);
        expq.push_back(64'h0);
        applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b1);
        tick();
        checkOutput("wrap_redir", 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, 32'd6);
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b1);
        tick();
        checkOutput("wrap_zero", 64'h0, 1'b1, 1'b0, 32'd6);
        tick();
        checkOutput("wrap_four", 64'h4, 1'b1, 1'b0, 32'd7);
        checkVal("wrap_four.instr_pc", instr_pc_o, 64'h0);
        tick();
        checkOutput("wrap_after", 64'h8, 1'b1, 1'b0, 32'd8);

        // Misaligned redirect traps; the fault state ignores every input.
        applyStimulus(1'b1, 64'h102, 1'b0, 1'b0);
        tick();
        checkOutput("fault_entry", 64'h102, 1'b0, 1'b1, 32'd8);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'(i % 2), 64'h40, 1'((i % 3) == 0), 1'((i % 2) == 0));
            tick();
            checkOutput("fault_hold", 64'h102, 1'b0, 1'b1, 32'd8);
        end

        // Reset clears the fault and all outputs.
        rst_n = 1'b0;
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0);
        tick();
        checkOutput("fault_reset", 64'h4, 1'b0, 1'b0, 32'd0);
        checkVal("fault_reset.instr",    64'(instr_o), 64'h0);
        checkVal("fault_reset.instr_pc", instr_pc_o,   64'h0);

        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", expq.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
